// File: rtl/kbd_pkg.sv
// -----------------------------------------------------------------------------
// kbd_pkg
// Shared constants for the PS/2 keyboard front end:
//   - set-2 scan codes (prefixes, arrows, WASD letters)
//   - ps2_rx receiver state encodings
//   - held-key index constants and scan-code lookup helpers
// No ports (package).
// -----------------------------------------------------------------------------
package kbd_pkg;

    // Set-2 prefixes
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    // Extended arrow codes (valid only after E0)
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;

    // Non-extended letter codes
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;

    // Receiver framing states
    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // Held-key indices
    localparam int NUM_KEYS  = 4;
    localparam int KEY_RIGHT = 0;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_FWD   = 2;
    localparam int KEY_BACK  = 3;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } key_hit_t;

    // Map an extended arrow code onto its held-key index.
    function automatic key_hit_t arrow_lookup(input logic [7:0] code);
        key_hit_t r;
        r.hit = 1'b1;
        r.idx = 2'd0;
        case (code)
            SC_RIGHT: r.idx = 2'(KEY_RIGHT);
            SC_LEFT:  r.idx = 2'(KEY_LEFT);
            SC_UP:    r.idx = 2'(KEY_FWD);
            SC_DOWN:  r.idx = 2'(KEY_BACK);
            default:  r.hit = 1'b0;
        endcase
        return r;
    endfunction

    // Map a non-extended WASD code onto its held-key index.
    function automatic key_hit_t wasd_lookup(input logic [7:0] code);
        key_hit_t r;
        r.hit = 1'b1;
        r.idx = 2'd0;
        case (code)
            SC_D:    r.idx = 2'(KEY_RIGHT);
            SC_A:    r.idx = 2'(KEY_LEFT);
            SC_W:    r.idx = 2'(KEY_FWD);
            SC_S:    r.idx = 2'(KEY_BACK);
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/keyboard_controls_if.sv
// -----------------------------------------------------------------------------
// keyboard_controls_if
// Bundles the PS/2 pad lines and the keyboard front-end outputs.
//   ps2_clk, ps2_dat       raw PS/2 lines (driven by the pad / master)
//   turn_right/turn_left   held arrow levels
//   move_forward/backward  held arrow levels
//   byte_valid             one-cycle pulse per good frame
//   byte_data[7:0]         last good byte
//   frame_err              one-cycle pulse per bad/timed-out frame
// Modports: slave = keyboard_controls side, master = pad/stimulus side.
// -----------------------------------------------------------------------------
interface keyboard_controls_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       turn_right;
    logic       turn_left;
    logic       move_forward;
    logic       move_backward;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    modport slave (
        input  ps2_clk, ps2_dat,
        output turn_right, turn_left, move_forward, move_backward,
        output byte_valid, byte_data, frame_err
    );

    modport master (
        output ps2_clk, ps2_dat,
        input  turn_right, turn_left, move_forward, move_backward,
        input  byte_valid, byte_data, frame_err
    );
endinterface

// File: rtl/keyboard_controls_ps2_rx.sv
// -----------------------------------------------------------------------------
// ps2_rx
// PS/2 device-to-host frame receiver.
//   clock          system clock
//   reset          asynchronous, active-low
//   ps2_clk/dat    raw pad lines (asynchronous)
//   byte_valid     one-cycle pulse: good frame (odd parity, stop==1)
//   byte_data[7:0] last good byte, held until the next byte_valid
//   frame_err      one-cycle pulse: parity/stop failure or mid-frame timeout
// Parameters: SYNC_STAGES (>=2) synchroniser depth, TIMEOUT_CYCLES idle clocks
// mid-frame before the partial frame is dropped.
// -----------------------------------------------------------------------------
module ps2_rx
    import kbd_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] dat_sync_reg;
    logic                   clk_prev_reg;
    logic                   clk_s;
    logic                   dat_s;
    logic                   fall;

    rx_state_t              state_reg;
    rx_state_t              state_next;
    logic [7:0]             shift_reg;
    logic [2:0]             bitcnt_reg;
    logic                   parity_reg;
    logic [TW-1:0]          to_cnt_reg;
    logic                   timeout_hit;
    logic                   frame_good;

    logic                   byte_valid_reg;
    logic                   byte_valid_next;
    logic                   frame_err_reg;
    logic                   frame_err_next;
    logic [7:0]             byte_data_reg;

    // Synchroniser chains: stage 0 samples the pad, each later stage the previous.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                clk_sync_reg[gi] <= 1'b0;
                dat_sync_reg[gi] <= 1'b0;
            end else if (gi == 0) begin
                clk_sync_reg[gi] <= ps2_clk;
                dat_sync_reg[gi] <= ps2_dat;
            end else begin
                clk_sync_reg[gi] <= clk_sync_reg[(gi == 0) ? 0 : gi-1];
                dat_sync_reg[gi] <= dat_sync_reg[(gi == 0) ? 0 : gi-1];
            end
        end
    end

    assign clk_s = clk_sync_reg[SYNC_STAGES-1];
    assign dat_s = dat_sync_reg[SYNC_STAGES-1];
    assign fall  = clk_prev_reg & ~clk_s;

    // Timeout only fires between falling edges while a frame is in progress.
    assign timeout_hit = (state_reg != RX_IDLE) && !fall &&
                         (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

    // Odd parity across data + parity bit, and a high stop bit.
    assign frame_good = dat_s & (^{parity_reg, shift_reg});

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_reg <= RX_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (timeout_hit) begin
            state_next = RX_IDLE;
        end else if (fall) begin
            case (state_reg)
                RX_IDLE:   if (!dat_s) state_next = RX_DATA;
                RX_DATA:   if (bitcnt_reg == 3'd7) state_next = RX_PARITY;
                RX_PARITY: state_next = RX_STOP;
                RX_STOP:   state_next = RX_IDLE;
                default:   state_next = RX_IDLE;
            endcase
        end
    end

    // Output logic (registered below)
    always_comb begin
        byte_valid_next = 1'b0;
        frame_err_next  = timeout_hit;
        if (fall && state_reg == RX_STOP) begin
            byte_valid_next = frame_good;
            frame_err_next  = ~frame_good;
        end
    end

    // Datapath: edge history, shifter, bit counter, parity, timeout, outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_prev_reg   <= 1'b0;
            shift_reg      <= '0;
            bitcnt_reg     <= '0;
            parity_reg     <= 1'b0;
            to_cnt_reg     <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            byte_data_reg  <= '0;
        end else begin
            clk_prev_reg <= clk_s;

            if (fall) begin
                case (state_reg)
                    RX_IDLE:   bitcnt_reg <= '0;
                    RX_DATA: begin
                        shift_reg  <= {dat_s, shift_reg[7:1]};
                        bitcnt_reg <= bitcnt_reg + 3'd1;
                    end
                    RX_PARITY: parity_reg <= dat_s;
                    default:   ;
                endcase
            end

            if (fall || state_reg == RX_IDLE) to_cnt_reg <= '0;
            else                               to_cnt_reg <= to_cnt_reg + TW'(1);

            byte_valid_reg <= byte_valid_next;
            frame_err_reg  <= frame_err_next;
            if (byte_valid_next) byte_data_reg <= shift_reg;
        end
    end

    assign byte_valid = byte_valid_reg;
    assign frame_err  = frame_err_reg;
    assign byte_data  = byte_data_reg;

endmodule

// File: rtl/keyboard_controls.sv
// -----------------------------------------------------------------------------
// keyboard_controls
// PS/2 keyboard front end for the player movement stage. Decodes set-2
// make/break codes into held-key levels for player_updater.
//   clock   system clock
//   reset   asynchronous, active-low
//   bus     keyboard_controls_if.slave: ps2_clk/ps2_dat in; turn_right,
//           turn_left, move_forward, move_backward, byte_valid, byte_data,
//           frame_err out
// Optional feature macro: KBD_WASD_EN -- non-extended W/A/S/D keys hold their
// own bits, OR-ed onto the arrow levels.
// Opposite keys may both read 1; one-hot arbitration happens downstream.
// -----------------------------------------------------------------------------
module keyboard_controls
    import kbd_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clock,
    input  logic                 reset,
    keyboard_controls_if.slave   bus
);

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_err;

    logic       ext_reg;
    logic       brk_reg;
    logic       is_prefix;
    key_hit_t   arrow_k;
    logic       arrow_reg [NUM_KEYS];
    logic [NUM_KEYS-1:0] key_level;

    ps2_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (bus.ps2_clk),
        .ps2_dat    (bus.ps2_dat),
        .byte_valid (rx_valid),
        .byte_data  (rx_data),
        .frame_err  (rx_err)
    );

    assign is_prefix = (rx_data == SC_EXT) || (rx_data == SC_BRK);
    assign arrow_k   = arrow_lookup(rx_data);

    // Prefix flags: any non-prefix byte consumes them; a bad frame drops them
    // so a lost break byte cannot turn the next code into a break.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
        end else if (rx_err) begin
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
        end else if (rx_valid) begin
            if (rx_data == SC_EXT) begin
                ext_reg <= 1'b1;
            end else if (rx_data == SC_BRK) begin
                brk_reg <= 1'b1;
            end else begin
                ext_reg <= 1'b0;
                brk_reg <= 1'b0;
            end
        end
    end

    // Arrow held bits: make sets, break clears; repeats are idempotent.
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_arrow
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                arrow_reg[gi] <= 1'b0;
            end else if (rx_valid && !is_prefix && ext_reg &&
                         arrow_k.hit && arrow_k.idx == 2'(gi)) begin
                arrow_reg[gi] <= ~brk_reg;
            end
        end
    end

`ifdef KBD_WASD_EN
    key_hit_t wasd_k;
    logic     letter_reg [NUM_KEYS];

    assign wasd_k = wasd_lookup(rx_data);

    // Letter bits are tracked separately so releasing one source never
    // clears a key still held through the other.
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_letter
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                letter_reg[gi] <= 1'b0;
            end else if (rx_valid && !is_prefix && !ext_reg &&
                         wasd_k.hit && wasd_k.idx == 2'(gi)) begin
                letter_reg[gi] <= ~brk_reg;
            end
        end
        assign key_level[gi] = arrow_reg[gi] | letter_reg[gi];
    end
`else
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_level
        assign key_level[gi] = arrow_reg[gi];
    end
`endif

    assign bus.turn_right    = key_level[KEY_RIGHT];
    assign bus.turn_left     = key_level[KEY_LEFT];
    assign bus.move_forward  = key_level[KEY_FWD];
    assign bus.move_backward = key_level[KEY_BACK];
    assign bus.byte_valid    = rx_valid;
    assign bus.byte_data     = rx_data;
    assign bus.frame_err     = rx_err;

endmodule

// File: tb/tb_keyboard_controls.sv
// -----------------------------------------------------------------------------
// tb_keyboard_controls
// Drives PS/2 frames into keyboard_controls. Each frame pushes its expected
// outcome (good byte or error, plus resulting key levels) into a scoreboard
// queue; a monitor pops an entry on every byte_valid/frame_err pulse and
// checks the key levels on the following clock.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_keyboard_controls;

    localparam int TO    = 300;   // shortened frame timeout
    localparam int HALF  = 6;     // PS/2 half-period in system clocks
    localparam int GAP   = 20;    // idle clocks between frames
    localparam int LIMIT = 60000; // overall cycle budget

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    keyboard_controls_if kbd_if ();

    keyboard_controls #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (kbd_if)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        logic [3:0] keys;   // {right, left, forward, backward}
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // ---------------- reference model ----------------
    // Key bits are named by direction: [3]=right [2]=left [1]=forward [0]=backward
    logic [3:0] m_arrow  = '0;
    logic [3:0] m_letter = '0;
    bit         m_ext    = 0;
    bit         m_brk    = 0;

    function automatic logic [3:0] model_keys();
        return m_arrow | m_letter;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (m_ext) begin
                if (b == 8'h74) m_arrow[3] = !m_brk;
                if (b == 8'h6B) m_arrow[2] = !m_brk;
                if (b == 8'h75) m_arrow[1] = !m_brk;
                if (b == 8'h72) m_arrow[0] = !m_brk;
            end
`ifdef KBD_WASD_EN
            else begin
                if (b == 8'h23) m_letter[3] = !m_brk;
                if (b == 8'h1C) m_letter[2] = !m_brk;
                if (b == 8'h1D) m_letter[1] = !m_brk;
                if (b == 8'h1B) m_letter[0] = !m_brk;
            end
`endif
            m_ext = 0;
            m_brk = 0;
        end
    endfunction

    function automatic void model_err();
        m_ext = 0;
        m_brk = 0;
    endfunction

    function automatic void model_reset();
        m_arrow  = '0;
        m_letter = '0;
        m_ext    = 0;
        m_brk    = 0;
    endfunction

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] dut_keys();
        return {kbd_if.turn_right, kbd_if.turn_left, kbd_if.move_forward, kbd_if.move_backward};
    endfunction

    // ---------------- PS/2 driver ----------------
    task automatic ps2_bit(input logic v);
        kbd_if.ps2_dat = v;
        repeat (HALF) @(posedge clock);
        kbd_if.ps2_clk = 1'b0;
        repeat (HALF) @(posedge clock);
        kbd_if.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        exp_t e;
        logic par;
        if (bad_par || bad_stop) begin
            model_err();
            e.is_err = 1; e.data = 8'h00;
        end else begin
            model_byte(b);
            e.is_err = 0; e.data = b;
        end
        e.keys = model_keys();
        sb.push_back(e);
        par = ~(^b);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par ^ bad_par);
        ps2_bit(~bad_stop);
        kbd_if.ps2_dat = 1'b1;
        repeat (GAP) @(posedge clock);
        $display("frame %02h par_err=%0d stop_err=%0d -> keys exp %04b", b, bad_par, bad_stop, e.keys);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 0, 0);
    endtask

    task automatic send_partial(input int nbits);
        exp_t e;
        model_err();
        e.is_err = 1; e.data = 8'h00; e.keys = model_keys();
        sb.push_back(e);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)));
        kbd_if.ps2_dat = 1'b1;
        repeat (TO + 40) @(posedge clock);
        $display("partial frame %0d bits, timeout -> keys exp %04b", nbits, e.keys);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset && (kbd_if.byte_valid || kbd_if.frame_err)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {kbd_if.byte_valid, kbd_if.frame_err}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_kind", {kbd_if.byte_valid, kbd_if.frame_err},
                        e.is_err ? 32'h1 : 32'h2);
                    if (!e.is_err) chk("byte_data", kbd_if.byte_data, e.data);
                    @(negedge clock);
                    chk("keys", dut_keys(), e.keys);
                    chk("pulse_width", {kbd_if.byte_valid, kbd_if.frame_err}, 32'h0);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        repeat (LIMIT) @(posedge clock);
        $display("FAIL watchdog: cycle budget %0d exhausted, %0d entries pending", LIMIT, sb.size());
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] pool [14];
        logic [7:0] b;
        int         k;
        pool = '{8'hE0, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h74, 8'h6B,
                 8'h75, 8'h72, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h00};

        kbd_if.ps2_clk = 1'b1;
        kbd_if.ps2_dat = 1'b1;
        reset = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        chk("reset_keys", dut_keys(), 32'h0);
        chk("reset_valid", kbd_if.byte_valid, 32'h0);
        chk("reset_err", kbd_if.frame_err, 32'h0);
        chk("reset_data", kbd_if.byte_data, 32'h0);
        reset = 1'b1;
        repeat (10) @(posedge clock);

        // forward make / break
        send_good(8'hE0); send_good(8'h75);
        send_good(8'hE0); send_good(8'hF0); send_good(8'h75);
        // bad parity after E0, then a clean make
        send_good(8'hE0); send_frame(8'h75, 1, 0);
        send_good(8'hE0); send_good(8'h75);
        // mid-frame stall, then left arrow
        send_partial(5);
        send_good(8'hE0); send_good(8'h6B);
        // keypad 8 (non-extended 75)
        send_good(8'h75);
        // simultaneous left + right, then release left
        send_good(8'hE0); send_good(8'h74);
        send_good(8'hE0); send_good(8'hF0); send_good(8'h6B);
        // bad stop bit
        send_frame(8'h72, 0, 1);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 19);
            if (k == 0)      send_frame(8'($urandom), 1, 0);
            else if (k == 1) send_frame(8'($urandom), 0, 1);
            else if (k == 2) send_partial($urandom_range(0, 9));
            else begin
                k = $urandom_range(0, 13);
                b = (k == 13) ? 8'($urandom) : pool[k];
                send_good(b);
            end
        end

        // reset mid-frame with backward held
        send_good(8'hE0); send_good(8'h72);
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        #1;
        chk("midreset_keys", dut_keys(), 32'h0);
        chk("midreset_valid", kbd_if.byte_valid, 32'h0);
        chk("midreset_err", kbd_if.frame_err, 32'h0);
        chk("midreset_data", kbd_if.byte_data, 32'h0);
        kbd_if.ps2_clk = 1'b1;
        kbd_if.ps2_dat = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (10) @(posedge clock);
        send_good(8'hE0); send_good(8'h72);
        send_good(8'h1D);

        repeat (50) @(posedge clock);
        @(negedge clock);
        chk("scoreboard_drained", sb.size(), 32'h0);
        chk("final_keys", dut_keys(), model_keys());
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
